// File: rtl/debounce_edge_detect.sv
// debounce_edge_detect
//   Single-bit conditioning stage: optional two-flop input synchronizer,
//   saturating stability counter, registered debounced level and one-cycle
//   rise/fall strobes.
//
//   Configuration macro: DEBOUNCE_EDGE_SYNC_EN
//     defined   -> two-flop synchronizer in front, d may be asynchronous
//     undefined -> sample = d, caller keeps d synchronous to clk
//
//   Parameters:
//     STABLE_CYCLES  consecutive mismatching cycles to accept a level (1..255)
//     INIT_LEVEL     reset value of q and of the synchronizer flops
//
//   Ports:
//     clk      clock, all state updates on posedge
//     rst      synchronous active-high reset
//     d        raw input level
//     q        debounced level (registered)
//     rise     one-cycle strobe when q goes 0->1 (registered)
//     fall     one-cycle strobe when q goes 1->0 (registered)
//     pending  combinational, qualified input differs from q
`timescale 1ns/1ps
module debounce_edge_detect #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter logic        INIT_LEVEL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic pending
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic          sample;
  logic [CW-1:0] cnt;

`ifdef DEBOUNCE_EDGE_SYNC_EN
  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= INIT_LEVEL;
      s2 <= INIT_LEVEL;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign sample = s2;
`else
  assign sample = d;
`endif

  assign pending = (sample != q);

  // Any matching cycle clears the count; only an unbroken run of
  // STABLE_CYCLES mismatching edges moves q.
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= INIT_LEVEL;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else if (!pending) begin
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else if (cnt == LAST) begin
      q    <= sample;
      cnt  <= '0;
      rise <= sample;
      fall <= ~sample;
    end else begin
      cnt  <= cnt + 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end
  end

endmodule

// File: tb/tb_debounce_edge_detect.sv
// tb_debounce_edge_detect
//   Drives two instances (STABLE_CYCLES=4 and STABLE_CYCLES=1, INIT_LEVEL=0)
//   with the same directed and random stimulus and compares every output
//   after every edge against a history-based reference model. Follows the
//   DEBOUNCE_EDGE_SYNC_EN setting of the build.
`timescale 1ns/1ps
module tb_debounce_edge_detect;

  localparam int N = 4000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d   = 1'b0;

  logic q4, rise4, fall4, pend4;
  logic q1, rise1, fall1, pend1;

  debounce_edge_detect #(.STABLE_CYCLES(4), .INIT_LEVEL(1'b0)) dut4 (
    .clk(clk), .rst(rst), .d(d),
    .q(q4), .rise(rise4), .fall(fall4), .pending(pend4)
  );

  debounce_edge_detect #(.STABLE_CYCLES(1), .INIT_LEVEL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .d(d),
    .q(q1), .rise(rise1), .fall(fall1), .pending(pend1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Input history: value of d and rst present at edge k.
  logic d_hist [N];
  logic r_hist [N];
  int   k = 0;

  // Per-instance model state (index 0: S=4, index 1: S=1).
  int   s_of   [2] = '{4, 1};
  logic qm     [2];
  logic rm     [2];
  logic fm     [2];
  int   marker [2];

  task automatic check(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s edge=%0d got=%0b exp=%0b", tag, k, got, exp);
    end
  endtask

  // Qualified input as seen by the counter logic just before edge j.
  function automatic logic samp(input int j);
`ifdef DEBOUNCE_EDGE_SYNC_EN
    if (j - 1 < 0 || r_hist[j-1]) return 1'b0;
    if (j - 2 < 0 || r_hist[j-2]) return 1'b0;
    return d_hist[j-2];
`else
    return d_hist[j];
`endif
  endfunction

  // Qualified input right after edge kk (d still holds its pre-edge value).
  function automatic logic samp_after(input int kk);
`ifdef DEBOUNCE_EDGE_SYNC_EN
    return samp(kk + 1);
`else
    return d_hist[kk];
`endif
  endfunction

  // Accept at edge kk iff the last S edges all came after the previous
  // reset/accept and every one of them saw a sample different from q.
  task automatic model_edge(input int i, input int kk);
    logic acc;
    int   s;
    s = s_of[i];
    if (r_hist[kk]) begin
      qm[i] = 1'b0; rm[i] = 1'b0; fm[i] = 1'b0; marker[i] = kk;
    end else begin
      acc = (kk - marker[i] >= s);
      for (int j = kk - s + 1; j <= kk; j++)
        if (acc && samp(j) == qm[i]) acc = 1'b0;
      if (acc) begin
        rm[i] = samp(kk); fm[i] = ~samp(kk); qm[i] = samp(kk); marker[i] = kk;
      end else begin
        rm[i] = 1'b0; fm[i] = 1'b0;
      end
    end
  endtask

  task automatic step(input logic rv, input logic dv);
    @(negedge clk);
    rst = rv;
    d   = dv;
    @(posedge clk);
    d_hist[k] = dv;
    r_hist[k] = rv;
    model_edge(0, k);
    model_edge(1, k);
    #1;
    check("q_s4",       q4,    qm[0]);
    check("rise_s4",    rise4, rm[0]);
    check("fall_s4",    fall4, fm[0]);
    check("pending_s4", pend4, samp_after(k) != qm[0]);
    check("q_s1",       q1,    qm[1]);
    check("rise_s1",    rise1, rm[1]);
    check("fall_s1",    fall1, fm[1]);
    check("pending_s1", pend1, samp_after(k) != qm[1]);
    check("no_dual_s4", rise4 & fall4, 1'b0);
    k++;
  endtask

  task automatic hold(input logic dv, input int n);
    for (int i = 0; i < n; i++) step(1'b0, dv);
  endtask

  initial begin
    logic pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int   len;
    logic lvl;

    for (int i = 0; i < 2; i++) begin
      qm[i] = 1'b0; rm[i] = 1'b0; fm[i] = 1'b0; marker[i] = -1;
    end

    // Reset held 3 cycles with d=1, then release and let q rise.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    hold(1'b1, 10);

    // Clean fall then clean rise.
    hold(1'b0, 10);
    hold(1'b1, 10);
    hold(1'b0, 10);

    // Glitch: 3 cycles high, then low.
    hold(1'b1, 3);
    hold(1'b0, 10);

    // Bounce then settle high.
    foreach (pat[i]) step(1'b0, pat[i]);
    hold(1'b1, 10);
    hold(1'b0, 10);

    // Reset mid-qualification.
    hold(1'b1, 4);
    step(1'b1, 1'b1);
    hold(1'b1, 10);
    hold(1'b0, 10);

    // Toggle every 2 cycles.
    for (int i = 0; i < 12; i++) hold(i[0] ? 1'b0 : 1'b1, 2);
    hold(1'b0, 8);

    // Random runs with occasional reset.
    lvl = 1'b0;
    while (k < N - 20) begin
      lvl = ~lvl;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len && k < N - 20; i++)
        step(($urandom_range(0, 59) == 0), lvl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/debounce_edge_detect.md
# debounce_edge_detect

Single-bit conditioning stage that consumes a raw or externally registered level (e.g. a flip-flop output from the FF_LATCH blocks) and produces a clean, debounced level plus one-cycle rise/fall strobes. An optional two-flop input synchronizer sits in front of a saturating stability counter. The counter accepts a new level only after it has held for a programmable number of consecutive cycles. Downstream logic uses `q` as a glitch-free level and `rise`/`fall` as single-cycle event strobes.

## Interface
- `STABLE_CYCLES`, default 4: consecutive mismatching cycles required to accept a new level. Legal range 1..255.
- `INIT_LEVEL`, default 1'b0: reset value of `q` and of the synchronizer flops.
- `clk` input, 1 bit: single clock. All state updates on the posedge.
- `rst` input, 1 bit: synchronous, active-high reset. It is sampled on the posedge of `clk` and has priority over all other behaviour.
- `d` input, 1 bit: raw level. It may be asynchronous to `clk` when the synchronizer is compiled in.
- `q` output, 1 bit: debounced level, registered.
- `rise` output, 1 bit: one-cycle strobe, registered, asserted on the cycle `q` goes 0→1.
- `fall` output, 1 bit: one-cycle strobe, registered, asserted on the cycle `q` goes 1→0.
- `pending` output, 1 bit: combinational, `sample != q`. High while a candidate level is being qualified.

## Operation
- Reset values: `q`=`INIT_LEVEL`, `rise`=0, `fall`=0. Internal `cnt`=0. Synchronizer flops `s1`=`s2`=`INIT_LEVEL`.
- `sample` is the qualified input:
  - With the synchronizer: `sample`=`s2`, where `s1`<=`d` and `s2`<=`s1`.
  - Without it: `sample`=`d`.
- Counter width is `$clog2(STABLE_CYCLES+1)` and is derived internally. `cnt` never exceeds `STABLE_CYCLES-1`.
- State is implied by (`pending`, `cnt`):
  - STABLE: `sample == q`. On each posedge `cnt`<=0, `rise`<=0, `fall`<=0.
  - QUALIFY: `sample != q` and `cnt < STABLE_CYCLES-1`. On each posedge `cnt`<=`cnt+1` and the strobes are 0.
  - ACCEPT: `sample != q` and `cnt == STABLE_CYCLES-1`. On the posedge:
    - `q`<=`sample` and `cnt`<=0.
    - `rise`<=`sample`, `fall`<=`~sample`.
    - Next cycle is STABLE (strobe high for exactly that one cycle).
- A glitch is any mismatch shorter than `STABLE_CYCLES` cycles. It returns to STABLE with `cnt` cleared, `q` unchanged and no strobe.
- There is no partial-credit memory: any single matching cycle clears `cnt`, and requalification starts from 0.
- With `STABLE_CYCLES`=1, `q` follows `sample` one edge later. Each transition still gives a one-cycle strobe.
- `rise` and `fall` are never high in the same cycle.
- Back-to-back accepted transitions are at least `STABLE_CYCLES` cycles apart.
- Reset mid-qualification discards the count and forces the reset values on that edge, with no strobe. The first post-reset qualification starts at `cnt`=0.

## Timing
- All outputs except `pending` are registered. There is no combinational path from `d` to `q`, `rise` or `fall`.
- Latency is counted from `d` changing before posedge E0 and then holding:
  - With the synchronizer: `q` and the strobe update at edge E0+`STABLE_CYCLES`+1, i.e. visible `STABLE_CYCLES`+2 cycles after the change.
  - Without the synchronizer: `q` updates at E0+`STABLE_CYCLES`-1, i.e. `STABLE_CYCLES` cycles after the change.
- Strobe width is exactly one `clk` period.
- `rst` asserted at an edge overrides a coincident ACCEPT.

## Configuration
- Macro: `DEBOUNCE_EDGE_SYNC_EN`.
- Defined:
  - Two-flop synchronizer `s1`/`s2` is present, and `d` may be fully asynchronous.
  - Latency is `STABLE_CYCLES`+2.
- Undefined:
  - Synchronizer is omitted and `sample`=`d`. The caller guarantees `d` is synchronous to `clk`.
  - Latency is `STABLE_CYCLES`.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use `STABLE_CYCLES`=4 and `INIT_LEVEL`=0, with `DEBOUNCE_EDGE_SYNC_EN` defined unless noted.
- Reset: hold `rst`=1 for 3 cycles with `d`=1. Then `q`=0, `rise`=`fall`=0 throughout, and `q` goes high 6 cycles after `rst` deasserts.
- Clean rise: `d` 0→1 and held. `q`=1 and `rise`=1 exactly 6 cycles later. `rise` is high for 1 cycle, `fall` stays 0.
- Glitch rejection: `d` pulses high for 3 cycles, then low. `q` stays 0, no strobe, and `pending` is high for 3 cycles.
- Bounce then settle: `d` pattern 1,0,1,1,0,1 then held at 1. `q` rises 6 cycles after the final 0→1, with a single `rise`.
- Reset mid-qualify: `d`=1 held, and `rst` pulsed 1 cycle when `cnt`=2. No strobe is produced, and `q` rises 6 cycles after `rst` deasserts.
- Macro undefined, `STABLE_CYCLES`=1: toggle `d` every 2 cycles. `q` tracks `d` with 1-cycle latency, and `rise`/`fall` alternate, one per transition.
